// File: rtl/mux_scan_ctrl_if.sv
// Handshake and data bundle between the scan sequencer and its controller/mux.
interface mux_scan_ctrl_if #(
  parameter int DWELL_W = 8
);
  logic               iStart;
  logic               iStop;
  logic               iMode;
  logic [7:0]         iMask;
  logic [DWELL_W-1:0] iDwell;
  logic               iMuxY;
  logic [2:0]         oSel;
  logic               oSample;
  logic [7:0]         oData;
  logic               oValid;
  logic               oBusy;

  modport master (
    output iStart, iStop, iMode, iMask, iDwell, iMuxY,
    input  oSel, oSample, oData, oValid, oBusy
  );

  modport slave (
    input  iStart, iStop, iMode, iMask, iDwell, iMuxY,
    output oSel, oSample, oData, oValid, oBusy
  );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Sweeps the 8:1 mux select over a masked channel set, dwelling on each,
// and publishes one 8-bit snapshot per sweep.
module mux_scan_ctrl #(
  parameter int DWELL_W = 8
) (
  input logic             iClk,
  input logic             iRst_n,
  mux_scan_ctrl_if.slave  bus
);
  typedef enum logic {IDLE, DWELL} state_t;

  state_t             state_q, state_d;
  logic [2:0]         sel_q, sel_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [7:0]         mask_q, mask_d;
  logic               mode_q, mode_d;
  logic [7:0]         shadow_q, shadow_d;
  logic [7:0]         data_q, data_d;
  logic               sample_q, sample_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic [7:0]         cap;

  function automatic logic [2:0] lowest(input logic [7:0] m);
    logic [2:0] r;
    r = '0;
    for (int i = 7; i >= 0; i--)
      if (m[i]) r = 3'(i);
    return r;
  endfunction

  function automatic logic [2:0] highest(input logic [7:0] m);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < 8; i++)
      if (m[i]) r = 3'(i);
    return r;
  endfunction

  // Lowest enabled channel strictly above s; only used when one exists.
  function automatic logic [2:0] next_above(input logic [7:0] m, input logic [2:0] s);
    logic [2:0] r;
    r = s;
    for (int i = 7; i >= 0; i--)
      if (m[i] && (i > int'(s))) r = 3'(i);
    return r;
  endfunction

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    dwell_d  = dwell_q;
    mask_d   = mask_q;
    mode_d   = mode_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    busy_d   = busy_q;
    sample_d = 1'b0;
    valid_d  = 1'b0;
    cap      = shadow_q;
    cap[sel_q] = bus.iMuxY;
    case (state_q)
      IDLE: begin
        if (bus.iStart && !bus.iStop && (bus.iMask != 8'h00)) begin
          mask_d   = bus.iMask;
          dwell_d  = bus.iDwell;
          mode_d   = bus.iMode;
          shadow_d = '0;
          sel_d    = lowest(bus.iMask);
          cnt_d    = bus.iDwell;
          busy_d   = 1'b1;
          state_d  = DWELL;
        end
      end
      DWELL: begin
        if (bus.iStop) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DWELL_W'(1);
        end else begin
          sample_d = 1'b1;
          shadow_d = cap;
          if (sel_q != highest(mask_q)) begin
            sel_d = next_above(mask_q, sel_q);
            cnt_d = dwell_q;
          end else begin
            data_d  = cap;
            valid_d = 1'b1;
            if (!mode_q) begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end else begin
              // Continuous wrap is a latch point, like a fresh start.
              mask_d  = bus.iMask;
              dwell_d = bus.iDwell;
              mode_d  = bus.iMode;
              if (bus.iMask != 8'h00) begin
                shadow_d = '0;
                sel_d    = lowest(bus.iMask);
                cnt_d    = bus.iDwell;
              end else begin
                state_d = IDLE;
                busy_d  = 1'b0;
              end
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      cnt_q    <= '0;
      dwell_q  <= '0;
      mask_q   <= '0;
      mode_q   <= 1'b0;
      shadow_q <= '0;
      data_q   <= '0;
      sample_q <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      dwell_q  <= dwell_d;
      mask_q   <= mask_d;
      mode_q   <= mode_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.oSel    = sel_q;
  assign bus.oSample = sample_q;
  assign bus.oData   = data_q;
  assign bus.oValid  = valid_q;
  assign bus.oBusy   = busy_q;
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl; expected snapshots are queued at start
// and checked whenever oValid fires.
module tb_mux_scan_ctrl;
  localparam int DWELL_W = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] pattern = 8'h00;
  logic [7:0] exp_q[$];
  int         ntests = 0;
  int         nfail = 0;
  int         nsamp = 0;
  int         nvalid = 0;
  int         nbusy = 0;
  int         v0;
  logic [2:0] exp_sel[4];

  always #5 clk = ~clk;

  mux_scan_ctrl_if #(.DWELL_W(DWELL_W)) ifc ();
  assign ifc.iMuxY = pattern[ifc.oSel];

  mux_scan_ctrl #(.DWELL_W(DWELL_W)) dut (
    .iClk   (clk),
    .iRst_n (rst_n),
    .bus    (ifc.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    ntests++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic clr_counts();
    nsamp = 0; nvalid = 0; nbusy = 0;
  endtask

  task automatic tick();
    logic [7:0] e;
    @(posedge clk);
    #1;
    if (ifc.oSample === 1'b1) nsamp++;
    if (ifc.oBusy === 1'b1) nbusy++;
    if (ifc.oValid === 1'b1) begin
      nvalid++;
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("snapshot", ifc.oData, e);
      end
    end
  endtask

  initial begin
    ifc.iStart = 0; ifc.iStop = 0; ifc.iMode = 0; ifc.iMask = 0; ifc.iDwell = 0;
    exp_sel[0] = 3'd0; exp_sel[1] = 3'd2; exp_sel[2] = 3'd5; exp_sel[3] = 3'd7;

    // Reset state
    tick(); tick();
    chk("rst_sel", ifc.oSel, 0);
    chk("rst_data", ifc.oData, 0);
    chk("rst_flags", {ifc.oSample, ifc.oValid, ifc.oBusy}, 0);
    rst_n = 1; tick();

    // Single sweep, mask A5, dwell 2
    clr_counts();
    ifc.iMask = 8'hA5; ifc.iDwell = 2; ifc.iMode = 0; pattern = 8'h81; ifc.iStart = 1;
    exp_q.push_back(8'h81);
    tick(); ifc.iStart = 0;
    for (int i = 0; i < 12; i++) begin
      chk("single_sel", ifc.oSel, exp_sel[i/3]);
      chk("single_busy", ifc.oBusy, 1);
      tick();
    end
    chk("single_end", {ifc.oValid, ifc.oSample, ifc.oBusy}, 3'b110);
    chk("single_nsamp", nsamp, 4);
    chk("single_nvalid", nvalid, 1);
    chk("single_nbusy", nbusy, 12);
    tick();
    chk("single_quiet", {ifc.oValid, ifc.oSample, ifc.oBusy}, 0);

    // Zero mask start ignored
    clr_counts();
    ifc.iMask = 8'h00; ifc.iStart = 1; tick(); ifc.iStart = 0; tick(); tick();
    chk("zmask_busy", nbusy, 0);
    chk("zmask_samp", nsamp + nvalid, 0);
    chk("zmask_data", ifc.oData, 8'h81);

    // Continuous, single channel 7, dwell 0
    clr_counts();
    ifc.iMode = 1; ifc.iMask = 8'h80; ifc.iDwell = 0; pattern = 8'hFF; ifc.iStart = 1;
    tick(); ifc.iStart = 0;
    chk("cont_sel0", ifc.oSel, 7);
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(8'h80);
      tick();
      chk("cont_sel", ifc.oSel, 7);
      chk("cont_strobes", {ifc.oSample, ifc.oValid, ifc.oBusy}, 3'b111);
    end
    ifc.iMask = 8'h03;
    exp_q.push_back(8'h80);
    tick();
    chk("cont_wrap_sel", ifc.oSel, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("cont_alt_sel1", ifc.oSel, 1);
      chk("cont_alt_novalid", ifc.oValid, 0);
      exp_q.push_back(8'h03);
      tick();
      chk("cont_alt_sel0", ifc.oSel, 0);
      chk("cont_alt_valid", ifc.oValid, 1);
    end
    v0 = nvalid;
    ifc.iStop = 1; tick(); ifc.iStop = 0;
    chk("cont_stop", {ifc.oBusy, ifc.oValid, ifc.oSample}, 0);
    chk("cont_stop_nvalid", nvalid, v0);
    chk("cont_stop_data", ifc.oData, 8'h03);

    // Prior sweep to 81, then stop mid-sweep
    ifc.iMode = 0; ifc.iMask = 8'h81; ifc.iDwell = 0; pattern = 8'h81; ifc.iStart = 1;
    exp_q.push_back(8'h81);
    tick(); ifc.iStart = 0; tick(); tick();
    chk("prior_data", ifc.oData, 8'h81);
    clr_counts();
    ifc.iMask = 8'hFF; ifc.iDwell = 3; ifc.iStart = 1;
    tick(); ifc.iStart = 0;
    for (int i = 0; i < 9; i++) tick();
    chk("stop_prebusy", nbusy, 10);
    ifc.iStop = 1; tick(); ifc.iStop = 0;
    chk("stop_flags", {ifc.oBusy, ifc.oValid, ifc.oSample}, 0);
    chk("stop_sel_hold", ifc.oSel, 2);
    chk("stop_data", ifc.oData, 8'h81);
    chk("stop_nvalid", nvalid, 0);
    ifc.iStart = 1; tick(); ifc.iStart = 0;
    chk("restart_sel", ifc.oSel, 0);
    chk("restart_busy", ifc.oBusy, 1);
    tick(); tick();

    // Reset mid-sweep
    rst_n = 0; tick(); rst_n = 1;
    chk("midrst_sel", ifc.oSel, 0);
    chk("midrst_data", ifc.oData, 0);
    chk("midrst_flags", {ifc.oSample, ifc.oValid, ifc.oBusy}, 0);
    clr_counts();
    ifc.iStart = 1; ifc.iStop = 1; tick(); ifc.iStart = 0; ifc.iStop = 0; tick();
    chk("startstop_idle", nbusy + nsamp + nvalid, 0);

    // Start pulses while busy are ignored
    clr_counts();
    ifc.iMask = 8'hA5; ifc.iDwell = 2; ifc.iMode = 0; pattern = 8'h81; ifc.iStart = 1;
    exp_q.push_back(8'h81);
    tick(); ifc.iStart = 0;
    for (int i = 0; i < 12; i++) begin
      chk("busystart_sel", ifc.oSel, exp_sel[i/3]);
      ifc.iStart = (i == 3 || i == 7);
      ifc.iMask = (i == 3 || i == 7) ? 8'hFF : 8'hA5;
      tick();
    end
    ifc.iStart = 0; ifc.iMask = 8'hA5;
    chk("busystart_end", {ifc.oValid, ifc.oBusy}, 2'b10);
    chk("busystart_nbusy", nbusy, 12);
    chk("busystart_nsamp", nsamp, 4);
    tick();
    chk("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
